// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and command-strobe bundle between the UART receiver,
// the command sequencer and the clock core.
//   rx_byte/rx_valid        : received byte and its one-cycle valid pulse
//   time_set, time_h/m/s    : set-time strobe with BCD hours/minutes/seconds
//   alarm_set, alarm_h/m    : set-alarm strobe with BCD hours/minutes
//   mode_set, mode          : set-mode strobe with 2-bit mode
//   frame_err, err_code     : rejected-frame strobe and last error code
//   busy                    : sequencer is inside a frame
// slave modport is the sequencer side, master is the byte-source/observer side.
interface uart_cmd_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       time_set;
  logic [7:0] time_h;
  logic [7:0] time_m;
  logic [7:0] time_s;
  logic       alarm_set;
  logic [7:0] alarm_h;
  logic [7:0] alarm_m;
  logic       mode_set;
  logic [1:0] mode;
  logic       frame_err;
  logic [2:0] err_code;
  logic       busy;

  modport slave (
    input  rx_byte, rx_valid,
    output time_set, time_h, time_m, time_s,
    output alarm_set, alarm_h, alarm_m,
    output mode_set, mode, frame_err, err_code, busy
  );

  modport master (
    output rx_byte, rx_valid,
    input  time_set, time_h, time_m, time_s,
    input  alarm_set, alarm_h, alarm_m,
    input  mode_set, mode, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Framed command parser between the UART byte receiver and the clock core.
// Frame: AA, CMD, LEN, LEN payload bytes, CSUM, 55. Validated commands
// leave as one-cycle strobes with registered data; rejected frames pulse
// frame_err with a code held in err_code.
// Ports: clk, rst (synchronous, active-high), bus (uart_cmd_ctrl_if.slave).
module uart_cmd_ctrl #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned TIMEOUT_MS = 10,
  parameter int unsigned MAX_LEN    = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_cmd_ctrl_if.slave bus
);
  localparam int unsigned TO_MAX = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int unsigned TW     = $clog2(TO_MAX + 1);
  localparam int unsigned IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_DATA, S_CSUM, S_TAIL, S_EXEC
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    cmd, len, csum;
  logic [IW-1:0] idx;
  logic [7:0]    pbuf [MAX_LEN];
  logic [TW-1:0] to_cnt;
  logic [2:0]    err_c;
  logic          time_set_c, alarm_set_c, mode_set_c, timeout_c;

  function automatic logic bcd_ok(input logic [7:0] b, input logic [7:0] lim);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= lim);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one byte per step, any error forces IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.rx_valid && bus.rx_byte == 8'hAA) state_nxt = S_CMD;
      S_CMD:  if (bus.rx_valid) state_nxt = S_LEN;
      S_LEN:  if (bus.rx_valid) state_nxt = (bus.rx_byte == 8'd0) ? S_CSUM : S_DATA;
      S_DATA: if (bus.rx_valid && 8'(idx) == len - 8'd1) state_nxt = S_CSUM;
      S_CSUM: if (bus.rx_valid) state_nxt = S_TAIL;
      S_TAIL: if (bus.rx_valid) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (err_c != 3'd0) state_nxt = S_IDLE;
  end

  // Output decode: error classification and command execution
  always_comb begin
    err_c       = 3'd0;
    time_set_c  = 1'b0;
    alarm_set_c = 1'b0;
    mode_set_c  = 1'b0;
    // a byte arriving on the limit cycle wins over the timeout
    timeout_c   = (state != S_IDLE) && (state != S_EXEC) && !bus.rx_valid &&
                  (to_cnt == TW'(TO_MAX - 1));
    case (state)
      S_LEN:  if (bus.rx_valid && bus.rx_byte > 8'(MAX_LEN)) err_c = 3'd2;
      S_CSUM: if (bus.rx_valid && bus.rx_byte != csum) err_c = 3'd3;
      S_TAIL: if (bus.rx_valid && bus.rx_byte != 8'h55) err_c = 3'd4;
      S_EXEC: begin
        case (cmd)
          8'h01: begin
            if (len != 8'd3) err_c = 3'd5;
            else if (!(bcd_ok(pbuf[0], 8'h23) && bcd_ok(pbuf[1], 8'h59) &&
                       bcd_ok(pbuf[2], 8'h59))) err_c = 3'd6;
            else time_set_c = 1'b1;
          end
          8'h02: begin
            if (len != 8'd2) err_c = 3'd5;
            else if (!(bcd_ok(pbuf[0], 8'h23) && bcd_ok(pbuf[1], 8'h59))) err_c = 3'd6;
            else alarm_set_c = 1'b1;
          end
          8'h03: begin
            if (len != 8'd1) err_c = 3'd5;
            else if (pbuf[0] > 8'h03) err_c = 3'd6;
            else mode_set_c = 1'b1;
          end
          default: err_c = 3'd5;
        endcase
      end
      default: ;
    endcase
    if (timeout_c) err_c = 3'd1;
  end

  // Frame fields, running checksum, payload index and inter-byte timer
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd    <= 8'd0;
      len    <= 8'd0;
      csum   <= 8'd0;
      idx    <= '0;
      to_cnt <= '0;
    end else begin
      if (bus.rx_valid || state_nxt == S_IDLE || state_nxt == S_EXEC) to_cnt <= '0;
      else to_cnt <= to_cnt + TW'(1);
      case (state)
        S_IDLE: if (bus.rx_valid && bus.rx_byte == 8'hAA) begin
          csum <= 8'd0;
          idx  <= '0;
        end
        S_CMD: if (bus.rx_valid) begin
          cmd  <= bus.rx_byte;
          csum <= csum + bus.rx_byte;
        end
        S_LEN: if (bus.rx_valid) begin
          len  <= bus.rx_byte;
          csum <= csum + bus.rx_byte;
        end
        S_DATA: if (bus.rx_valid) begin
          csum <= csum + bus.rx_byte;
          idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Payload buffer; only read after a full payload has been written
  always_ff @(posedge clk) begin
    if (state == S_DATA && bus.rx_valid) pbuf[idx] <= bus.rx_byte;
  end

  // Registered outputs; data registers move only with their own strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.time_set  <= 1'b0;
      bus.time_h    <= 8'd0;
      bus.time_m    <= 8'd0;
      bus.time_s    <= 8'd0;
      bus.alarm_set <= 1'b0;
      bus.alarm_h   <= 8'd0;
      bus.alarm_m   <= 8'd0;
      bus.mode_set  <= 1'b0;
      bus.mode      <= 2'd0;
      bus.frame_err <= 1'b0;
      bus.err_code  <= 3'd0;
      bus.busy      <= 1'b0;
    end else begin
      bus.time_set  <= time_set_c;
      bus.alarm_set <= alarm_set_c;
      bus.mode_set  <= mode_set_c;
      bus.frame_err <= (err_c != 3'd0);
      bus.busy      <= (state_nxt != S_IDLE);
      if (time_set_c) begin
        bus.time_h <= pbuf[0];
        bus.time_m <= pbuf[1];
        bus.time_s <= pbuf[2];
      end
      if (alarm_set_c) begin
        bus.alarm_h <= pbuf[0];
        bus.alarm_m <= pbuf[1];
      end
      if (mode_set_c) bus.mode <= pbuf[0][1:0];
      if (err_c != 3'd0) bus.err_code <= err_c;
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl (TO_MAX = 10000/1000*5 = 50).
module tb_uart_cmd_ctrl;
  localparam int unsigned TO_MAX = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.CLK_FREQ(10000), .TIMEOUT_MS(5), .MAX_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_ts = 0, cnt_as = 0, cnt_ms = 0, cnt_fe = 0, excl_bad = 0;
  logic [7:0] fr [$];

  // Strobe pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.time_set)  cnt_ts++;
      if (bus.alarm_set) cnt_as++;
      if (bus.mode_set)  cnt_ms++;
      if (bus.frame_err) cnt_fe++;
      if (32'(bus.time_set) + 32'(bus.alarm_set) + 32'(bus.mode_set) +
          32'(bus.frame_err) > 32'd1) excl_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_data", 64'({bus.time_h, bus.time_m, bus.time_s, bus.alarm_h, bus.alarm_m, bus.mode}), 64'd0);
    chk("reset_ctl", 64'({bus.time_set, bus.alarm_set, bus.mode_set, bus.frame_err, bus.err_code, bus.busy}), 64'd0);

    // Set time 12:34:56
    send(8'hAA);
    chk("busy_hdr", 64'(bus.busy), 64'd1);
    fr = '{8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'hA0, 8'h55};
    send_fr();
    chk("exec_busy", 64'({bus.busy, bus.time_set}), 64'b10);
    step();
    chk("time_set", 64'({bus.time_set, bus.busy, bus.frame_err}), 64'b100);
    chk("time_val", 64'({bus.time_h, bus.time_m, bus.time_s}), 64'h123456);
    step();
    chk("time_set_1cyc", 64'(bus.time_set), 64'd0);

    // Set alarm 07:30, then mode 2 with header at N+2
    fr = '{8'hAA, 8'h02, 8'h02, 8'h07, 8'h30, 8'h3B, 8'h55};
    send_fr();
    step();
    chk("alarm_set", 64'(bus.alarm_set), 64'd1);
    chk("alarm_val", 64'({bus.alarm_h, bus.alarm_m}), 64'h0730);
    fr = '{8'hAA, 8'h03, 8'h01, 8'h02, 8'h06, 8'h55};
    send_fr();
    step();
    chk("mode_set", 64'({bus.mode_set, bus.mode}), 64'b110);

    // Checksum error; trailing 55 ignored in IDLE
    fr = '{8'hAA, 8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'hA1};
    send_fr();
    chk("csum_err", 64'({bus.frame_err, bus.err_code, bus.busy}), 64'({1'b1, 3'd3, 1'b0}));
    send(8'h55);
    chk("csum_tail_ignored", 64'({bus.frame_err, bus.busy}), 64'd0);
    chk("csum_time_hold", 64'({bus.time_h, bus.time_m, bus.time_s}), 64'h123456);
    fr = '{8'hAA, 8'h01, 8'h03, 8'h21, 8'h45, 8'h09, 8'h73, 8'h55};
    send_fr();
    step();
    chk("recover_time", 64'({bus.time_set, bus.time_h, bus.time_m, bus.time_s}), 64'h1214509);

    // Hours out of range
    fr = '{8'hAA, 8'h01, 8'h03, 8'h24, 8'h34, 8'h56, 8'hB2, 8'h55};
    send_fr();
    step();
    chk("range_err", 64'({bus.frame_err, bus.err_code, bus.time_set}), 64'({1'b1, 3'd6, 1'b0}));
    chk("range_time_hold", 64'({bus.time_h, bus.time_m, bus.time_s}), 64'h214509);

    // LEN above MAX_LEN
    send(8'hAA); send(8'h01); send(8'h09);
    chk("len_err", 64'({bus.frame_err, bus.err_code, bus.busy}), 64'({1'b1, 3'd2, 1'b0}));

    // Unknown command with LEN 0
    fr = '{8'hAA, 8'h04, 8'h00, 8'h04, 8'h55};
    send_fr();
    step();
    chk("unk_cmd", 64'({bus.frame_err, bus.err_code}), 64'({1'b1, 3'd5}));

    // LEN = MAX_LEN is legal framing, but mismatches the set-time entry
    fr = '{8'hAA, 8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h55};
    send_fr();
    chk("len_max_busy", 64'({bus.busy, bus.frame_err}), 64'b10);
    step();
    chk("len_mismatch", 64'({bus.frame_err, bus.err_code}), 64'({1'b1, 3'd5}));

    // Timeout after AA 01
    send(8'hAA); send(8'h01);
    repeat (TO_MAX - 1) step();
    chk("to_not_yet", 64'({bus.frame_err, bus.busy}), 64'b01);
    step();
    chk("timeout", 64'({bus.frame_err, bus.err_code, bus.busy}), 64'({1'b1, 3'd1, 1'b0}));

    // Byte exactly on the limit cycle wins
    send(8'hAA); send(8'h01);
    repeat (TO_MAX - 1) step();
    send(8'h03);
    chk("to_byte_wins", 64'({bus.frame_err, bus.busy}), 64'b01);
    fr = '{8'h12, 8'h34, 8'h56, 8'hA0, 8'h55};
    send_fr();
    step();
    chk("to_frame_ok", 64'({bus.time_set, bus.time_h, bus.time_m, bus.time_s}), 64'h1123456);
    chk("err_code_held", 64'(bus.err_code), 64'd1);

    // Stray bytes in IDLE
    send(8'h00); send(8'h55); send(8'hFF);
    step();
    chk("stray_quiet", 64'({bus.frame_err, bus.busy}), 64'd0);
    chk("stray_fe_count", 64'(cnt_fe), 64'd6);

    // Reset mid-frame
    send(8'hAA); send(8'h01); send(8'h03); send(8'h12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_data", 64'({bus.time_h, bus.time_m, bus.time_s, bus.alarm_h, bus.alarm_m, bus.mode}), 64'd0);
    chk("rst_mid_ctl", 64'({bus.time_set, bus.alarm_set, bus.mode_set, bus.frame_err, bus.err_code, bus.busy}), 64'd0);
    fr = '{8'hAA, 8'h02, 8'h02, 8'h07, 8'h30, 8'h3B, 8'h55};
    send_fr();
    step();
    chk("post_rst_alarm", 64'({bus.alarm_set, bus.alarm_h, bus.alarm_m}), 64'h10730);
    chk("post_rst_time", 64'(bus.time_h), 64'd0);
    step();

    chk("cnt_time_set", 64'(cnt_ts), 64'd3);
    chk("cnt_alarm_set", 64'(cnt_as), 64'd2);
    chk("cnt_mode_set", 64'(cnt_ms), 64'd1);
    chk("cnt_frame_err", 64'(cnt_fe), 64'd6);
    chk("strobe_exclusive", 64'(excl_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
